// File: rtl/a2d_intf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | a2d_intf : SPI master for a 12-bit ADC, two 16-bit transactions per conv |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module a2d_intf (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  input  logic        MISO,
  output logic        a2d_SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        cnv_cmplt,
  output logic [11:0] A2D_res
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TXN1 = 2'd1,
    GAP  = 2'd2,
    TXN2 = 2'd3
  } state_t;

  localparam logic [4:0] C_DIV_INIT = 5'b10111;
  localparam logic [4:0] C_DIV_RISE = 5'b01111;
  localparam logic [4:0] C_DIV_FALL = 5'b11111;
  localparam logic [4:0] C_BITS     = 5'd16;
  localparam logic [4:0] C_GAP_LAST = 5'd31;

  state_t      state_q;
  logic        ss_n_q;
  logic [4:0]  sclk_div_q;
  logic [15:0] shift_q;
  logic        smpl_q;
  logic [4:0]  bit_cnt_q;
  logic [4:0]  gap_cnt_q;
  logic [2:0]  chnl_q;
  logic        cmplt_q;
  logic [11:0] res_q;

  logic w_rise;
  logic w_fall;
  logic w_txn_end;

  assign w_rise    = !ss_n_q && (sclk_div_q == C_DIV_RISE);
  // A fall before any rise (bit_cnt_q == 0) is the leading edge and shifts nothing.
  assign w_fall    = !ss_n_q && (sclk_div_q == C_DIV_FALL) && (bit_cnt_q != 5'd0);
  assign w_txn_end = !ss_n_q && (sclk_div_q == C_DIV_FALL) && (bit_cnt_q == C_BITS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ss_n_q     <= 1'b1;
      sclk_div_q <= 5'd0;
      shift_q    <= 16'h0000;
      smpl_q     <= 1'b0;
      bit_cnt_q  <= 5'd0;
      gap_cnt_q  <= 5'd0;
      chnl_q     <= 3'd0;
      cmplt_q    <= 1'b0;
      res_q      <= 12'h000;
    end else begin
      if (!ss_n_q)
        sclk_div_q <= sclk_div_q + 5'd1;
      if (w_rise) begin
        smpl_q    <= MISO;
        bit_cnt_q <= bit_cnt_q + 5'd1;
      end
      if (w_fall)
        shift_q <= {shift_q[14:0], smpl_q};

      case (state_q)
        IDLE: begin
          if (strt_cnv) begin
            chnl_q     <= chnnl;
            cmplt_q    <= 1'b0;
            ss_n_q     <= 1'b0;
            sclk_div_q <= C_DIV_INIT;
            shift_q    <= {2'b00, chnnl, 11'h000};
            state_q    <= TXN1;
          end
        end
        TXN1: begin
          if (w_txn_end) begin
            ss_n_q    <= 1'b1;
            bit_cnt_q <= 5'd0;
            gap_cnt_q <= 5'd0;
            state_q   <= GAP;
          end
        end
        GAP: begin
          gap_cnt_q <= gap_cnt_q + 5'd1;
          if (gap_cnt_q == C_GAP_LAST) begin
            ss_n_q     <= 1'b0;
            sclk_div_q <= C_DIV_INIT;
            shift_q    <= {2'b00, chnl_q, 11'h000};
            state_q    <= TXN2;
          end
        end
        TXN2: begin
          if (w_txn_end) begin
            ss_n_q    <= 1'b1;
            bit_cnt_q <= 5'd0;
            // Result is the post-shift low 12 bits, taken on the same edge as the final shift.
            res_q     <= {shift_q[10:0], smpl_q};
            cmplt_q   <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a2d_SS_n  = ss_n_q;
  assign SCLK      = ss_n_q | sclk_div_q[4];
  assign MOSI      = shift_q[15];
  assign cnv_cmplt = cmplt_q;
  assign A2D_res   = res_q;

endmodule
`default_nettype wire
